// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and serializer states.
package mmio_uart_pkg;

  // Register word index, taken from addr[3:2] inside the 16-byte window.
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;
  localparam logic [1:0] OFF_RSVD    = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  // A programmed divisor of zero still needs a one-clock bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO; a pop on the same edge frees a slot for a push
// into a full FIFO.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS/DIVISOR registers, byte FIFO and
// an 8N1 serializer whose bit length is latched at every bit boundary.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic        memRr,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  input  logic [3:0]  w_mask,
  input  logic [3:0]  r_mask,
  output logic [31:0] rdData,
  output logic        hit,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   r_state, w_state_nxt;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitidx;
  logic [15:0] r_timer, r_bitlen, r_div;
  logic        r_ovf;

  logic [1:0]    w_off;
  logic          w_wr, w_push_req, w_div_wr, w_ovf_clr, w_ovf_set;
  logic          w_pop, w_bit_end, w_bit_start;
  logic          w_fifo_full, w_fifo_empty;
  logic [7:0]    w_fifo_rdata;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status, w_rd_word;
  logic          w_unused;

  assign w_off      = addr[3:2];
  assign hit        = ce && (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr       = hit && we;
  assign w_push_req = w_wr && (w_off == OFF_TXDATA) && w_mask[0];
  assign w_div_wr   = w_wr && (w_off == OFF_DIVISOR) && (w_mask[1:0] == 2'b11);
  assign w_ovf_clr  = w_wr && (w_off == OFF_STATUS) && w_mask[0] && wtData[ST_OVF];
  assign w_ovf_set  = w_push_req && w_fifo_full && !w_pop;
  assign w_unused   = &{1'b0, addr[1:0], wtData[31:16], w_mask[3:2]};

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .gclk    (clk),
    .grst_n  (rst),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_wdata (wtData[7:0]),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign w_bit_end   = (r_state != S_IDLE) && (r_timer == r_bitlen - 16'd1);
  assign w_bit_start = w_pop || (w_bit_end && (w_state_nxt != S_IDLE));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    tx          = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        tx = r_shift[r_bitidx];
        if (w_bit_end && (r_bitidx == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A DIVISOR write only reaches the line when the next bit starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift  <= '0;
      r_bitidx <= '0;
      r_timer  <= '0;
      r_bitlen <= 16'd1;
    end else begin
      if (w_pop) r_shift <= w_fifo_rdata;
      if (r_state == S_DATA && w_bit_end) r_bitidx <= r_bitidx + 3'd1;
      r_timer <= (w_bit_end || r_state == S_IDLE) ? 16'd0 : r_timer + 16'd1;
      if (w_bit_start) r_bitlen <= eff_div(r_div);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= DIV_RESET;
      r_ovf <= 1'b0;
    end else begin
      if (w_div_wr) r_div <= wtData[15:0];
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status           = '0;
    w_status[ST_EMPTY] = (w_count == '0);
    w_status[ST_FULL]  = (w_count == CW'(FIFO_DEPTH));
    w_status[ST_BUSY]  = (r_state != S_IDLE);
    w_status[ST_OVF]   = r_ovf;
  end

  always_comb begin
    w_rd_word = '0;
    case (w_off)
      OFF_STATUS:  w_rd_word = w_status;
      OFF_DIVISOR: w_rd_word = {16'h0, r_div};
      default:     w_rd_word = '0;
    endcase
  end

  always_comb begin
    rdData = '0;
    if (hit && memRr) begin
      for (int i = 0; i < 4; i++)
        if (r_mask[i]) rdData[8*i +: 8] = w_rd_word[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register vector table, directed serial frames and
// randomized bursts checked against a queue/timeline model of the line.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 4;
  localparam int          NS    = 2048;

  logic        clk = 1'b0, rst = 1'b0, ce = 1'b0, we = 1'b0, memRr = 1'b0;
  logic [31:0] addr = '0, wtData = '0;
  logic [3:0]  w_mask = '0, r_mask = '0;
  logic [31:0] rdData;
  logic        hit, tx;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .memRr(memRr), .addr(addr),
    .wtData(wtData), .w_mask(w_mask), .r_mask(r_mask), .rdData(rdData),
    .hit(hit), .tx(tx)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // One bus cycle starting at a falling edge; tx is sampled before driving.
  task automatic bus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] rd,
                     output logic h, output logic t_s);
    @(negedge clk);
    t_s = tx;
    ce = 1'b1; we = wr; memRr = !wr; addr = a; wtData = d;
    w_mask = wr ? m : 4'h0;
    r_mask = wr ? 4'h0 : m;
    #1;
    rd = rdData;
    h  = hit;
    if (wr) begin
      @(posedge clk);
      #1;
    end
    ce = 1'b0; we = 1'b0; memRr = 1'b0; w_mask = '0; r_mask = '0;
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [3:0] m, output logic [31:0] v);
    logic h, t_s;
    bus(1'b0, a, 32'h0, m, v, h, t_s);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] rd;
    logic h, t_s;
    bus(1'b1, a, d, m, rd, h, t_s);
  endtask

  // Model state: writes at given cycles, one optional DIVISOR write.
  int          wr_t[$];
  logic [7:0]  wr_b[$];
  int          dw_t;
  logic [15:0] dw_v, div0;
  bit          ovf0;
  int          n_low, n_busy;
  logic        ex_tx[NS];
  bit          ex_busy[NS];
  int          ex_sz[NS];
  bit          ex_ov[NS];

  // Bit length of a bit that starts at edge t.
  function automatic int div_at(input int t);
    int d;
    d = (dw_t >= 0 && t > dw_t) ? int'(dw_v) : int'(div0);
    return (d == 0) ? 1 : d;
  endfunction

  // Sample i is taken at the falling edge before rising edge i.
  task automatic run(input string nm);
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [31:0] rd, exp_st;
    logic        h, t_s, v;
    int free_at, j, T, s, len, mis_tx, mis_st, wi;
    bit ovf;
    free_at = 0; j = 0; T = 0; mis_tx = 0; mis_st = 0; wi = 0; ovf = ovf0;
    for (int i = 0; i < NS; i++) begin
      ex_tx[i] = 1'b1; ex_busy[i] = 0; ex_sz[i] = 0; ex_ov[i] = ovf0;
    end
    for (int t = 0; t < NS - 100; t++) begin
      if (q.size() > 0 && t >= free_at) begin
        b = q.pop_front();
        s = t;
        for (int k = 0; k < 10; k++) begin
          len = div_at(s);
          v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
          for (int i = s + 1; i <= s + len; i++) begin
            ex_tx[i] = v; ex_busy[i] = 1;
          end
          s += len;
        end
        free_at = s;
      end
      if (j < wr_t.size() && wr_t[j] == t) begin
        if (q.size() < DEPTH) q.push_back(wr_b[j]);
        else ovf = 1;
        j++;
      end
      ex_sz[t] = q.size();
      ex_ov[t] = ovf;
      if (T == 0 && j == wr_t.size() && q.size() == 0 && t >= free_at) T = t + 3;
    end
    if (T == 0) T = NS - 100;
    if (dw_t >= T - 1) T = dw_t + 2;
    n_low = 0; n_busy = 0;
    for (int i = 0; i < T; i++) begin
      if (wi < wr_t.size() && wr_t[wi] == i) begin
        bus(1'b1, BASE, {24'h0, wr_b[wi]}, 4'h1, rd, h, t_s);
        wi++;
      end else if (i == dw_t) begin
        bus(1'b1, BASE + 32'h8, {16'h0, dw_v}, 4'h3, rd, h, t_s);
      end else begin
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, h, t_s);
        exp_st = '0;
        exp_st[3] = (i == 0) ? ovf0 : ex_ov[i-1];
        exp_st[2] = ex_busy[i];
        exp_st[1] = (i > 0) && (ex_sz[i-1] == DEPTH);
        exp_st[0] = (i == 0) || (ex_sz[i-1] == 0);
        if (rd !== exp_st) begin
          if (mis_st == 0)
            $display("  %s: first status divergence at cycle %0d: %h vs %h", nm, i, rd, exp_st);
          mis_st++;
        end
        if (rd[2]) n_busy++;
      end
      if (t_s !== ex_tx[i]) begin
        if (mis_tx == 0)
          $display("  %s: first tx divergence at cycle %0d: %b vs %b", nm, i, t_s, ex_tx[i]);
        mis_tx++;
      end
      if (t_s === 1'b0) n_low++;
    end
    check({nm, " tx waveform mismatches"}, mis_tx, 0);
    check({nm, " status mismatches"}, mis_st, 0);
    if (dw_t >= 0) div0 = dw_v;
    ovf0 = ovf;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp_rd;
    bit          exp_hit;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] rd;
    logic        h, t_s;
    int          n, t, hi;

    tbl[0]  = '{0, BASE + 32'h4,  32'h0,         4'hF, 32'h0000_0001, 1};
    tbl[1]  = '{0, BASE + 32'h8,  32'h0,         4'hF, 32'h0000_01B2, 1};
    tbl[2]  = '{1, BASE + 32'h8,  32'h0000_1234, 4'hF, 32'h0,         1};
    tbl[3]  = '{0, BASE + 32'h8,  32'h0,         4'h1, 32'h0000_0034, 1};
    tbl[4]  = '{1, BASE + 32'h8,  32'hFFFF_5678, 4'h1, 32'h0,         1};
    tbl[5]  = '{0, BASE + 32'h8,  32'h0,         4'hF, 32'h0000_1234, 1};
    tbl[6]  = '{0, BASE + 32'h8,  32'h0,         4'h2, 32'h0000_1200, 1};
    tbl[7]  = '{1, BASE + 32'hC,  32'hFFFF_FFFF, 4'hF, 32'h0,         1};
    tbl[8]  = '{0, BASE + 32'hC,  32'h0,         4'hF, 32'h0,         1};
    tbl[9]  = '{0, BASE,          32'h0,         4'hF, 32'h0,         1};
    tbl[10] = '{1, BASE + 32'h10, 32'h0000_00AA, 4'hF, 32'h0,         0};
    tbl[11] = '{0, BASE + 32'h18, 32'h0,         4'hF, 32'h0,         0};
    tbl[12] = '{0, BASE + 32'h4,  32'h0,         4'hF, 32'h0000_0001, 1};
    tbl[13] = '{1, BASE + 32'h8,  32'hABCD_0004, 4'h3, 32'h0,         1};
    tbl[14] = '{0, BASE + 32'h8,  32'h0,         4'hF, 32'h0000_0004, 1};

    // Reset state, observed while reset is still held.
    #1;
    check("reset tx", {31'h0, tx}, 32'h1);
    rd_reg(BASE + 32'h4, 4'hF, rd);
    check("reset status", rd, 32'h1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      bus(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].m, rd, h, t_s);
      check($sformatf("vec%0d rdData", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d hit", i), {31'h0, h}, {31'h0, tbl[i].exp_hit});
    end
    div0 = 16'd4;
    ovf0 = 0;

    // Single 0x55 frame at div=4.
    wr_t = '{0}; wr_b = '{8'h55}; dw_t = -1;
    run("frame55");
    check("frame55 tx low clocks", n_low, 20);
    check("frame55 busy clocks", n_busy, 40);

    // Five back-to-back bytes into a depth-4 FIFO.
    wr_t = '{0, 1, 2, 3, 4}; wr_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run("burst5");
    rd_reg(BASE + 32'h4, 4'hF, rd);
    check("burst5 final status", rd, 32'h1);

    // Sixth byte is dropped; overflow survives ignored clears.
    wr_t = '{0, 1, 2, 3, 4, 5}; wr_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    run("burst6");
    rd_reg(BASE + 32'h4, 4'hF, rd);
    check("burst6 status after drain", rd, 32'h9);
    wr_reg(BASE + 32'h4, 32'h8, 4'h2);
    rd_reg(BASE + 32'h4, 4'hF, rd);
    check("w1c wrong mask", rd, 32'h9);
    wr_reg(BASE + 32'h4, 32'h7, 4'h1);
    rd_reg(BASE + 32'h4, 4'hF, rd);
    check("w1c bit3 clear", rd, 32'h9);
    wr_reg(BASE + 32'h4, 32'h8, 4'h1);
    rd_reg(BASE + 32'h4, 4'hF, rd);
    check("w1c clears overflow", rd, 32'h1);
    ovf0 = 0;

    // DIVISOR change inside a data bit.
    wr_t = '{0}; wr_b = '{8'hA5}; dw_t = 7; dw_v = 16'd8;
    run("divchange");
    rd_reg(BASE + 32'h8, 4'hF, rd);
    check("divchange readback", rd, 32'h8);

    // Divisor 0 behaves as 1.
    wr_reg(BASE + 32'h8, 32'h0, 4'h3);
    div0 = 16'd0;
    wr_t = '{0, 1}; wr_b = '{8'h3C, 8'hC3}; dw_t = -1;
    run("div0");

    for (int r = 0; r < 10; r++) begin
      wr_t.delete(); wr_b.delete();
      n = int'($urandom_range(1, 6));
      t = 0;
      for (int k = 0; k < n; k++) begin
        wr_t.push_back(t);
        wr_b.push_back(8'($urandom));
        t += 1 + int'($urandom_range(0, 1)) * int'($urandom_range(0, 3));
      end
      dw_t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 25)) : -1;
      foreach (wr_t[k]) if (wr_t[k] == dw_t) dw_t = -1;
      dw_v = 16'($urandom_range(0, 6));
      run($sformatf("rand%0d", r));
    end

    // Reset in the middle of a data bit of a 0x00 frame.
    wr_reg(BASE + 32'h8, 32'h4, 4'h3);
    wr_reg(BASE, 32'h00, 4'h1);
    for (int i = 0; i < 7; i++) rd_reg(BASE + 32'h4, 4'hF, rd);
    check("pre-reset tx in data bit", {31'h0, tx}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("async reset tx", {31'h0, tx}, 32'h1);
    ce = 1'b1; memRr = 1'b1; addr = BASE + 32'h4; r_mask = 4'hF;
    #1;
    check("status in reset", rdData, 32'h1);
    ce = 1'b0; memRr = 1'b0; r_mask = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_reg(BASE + 32'h8, 4'hF, rd);
    check("div after reset", rd, 32'd434);
    rd_reg(BASE + 32'h4, 4'hF, rd);
    check("status after reset", rd, 32'h1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    check("tx idle after reset", hi, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
